// File: rtl/data_ram_resp_if.sv
// MEM-stage data-memory bus: request from the memory-access stage (master),
// response and stall request from the data RAM responder (slave).
interface data_ram_resp_if;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_ready_o;
   logic        mem_err_o;
   logic        stall_req_o;

   modport master (
      output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
      input  mem_data_o, mem_ready_o, mem_err_o, stall_req_o
   );

   modport slave (
      input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
      output mem_data_o, mem_ready_o, mem_err_o, stall_req_o
   );
endinterface

// File: rtl/data_ram_resp.sv
// Data-memory responder: word RAM with programmable wait states, registered read word and
// pipeline stall request. Define DRAM_ACCESS_CNT_EN to add saturating read/write access counters.
module data_ram_resp #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        resetn,
`ifdef DRAM_ACCESS_CNT_EN
   output logic [31:0] rd_cnt_o,
   output logic [31:0] wr_cnt_o,
`endif
   data_ram_resp_if.slave mem
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [3:0]       sel_q, sel_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;

   logic                  acc_we;
   logic [3:0]            acc_sel;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic                  in_range;
   logic                  go_resp;
   logic                  ram_we;

   logic [31:0] ram_q [0:DEPTH-1];

   // Access fields: live inputs while idle (zero-wait path), latched copy afterwards
   always_comb begin
      if (state_q == ST_IDLE) begin
         acc_we    = mem.mem_we_i;
         acc_sel   = mem.mem_sel_i;
         acc_addr  = mem.mem_addr_i;
         acc_wdata = mem.mem_data_i;
      end else begin
         acc_we    = we_q;
         acc_sel   = sel_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
      end
   end

   assign acc_idx  = acc_addr[ADDR_WIDTH+1:2];
   assign in_range = (acc_addr >> (ADDR_WIDTH + 2)) == 32'd0;

   // Next-state and response logic; the RAM access happens on the edge entering RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      go_resp = 1'b0;
      ram_we  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem.mem_ce_i) begin
               we_d    = mem.mem_we_i;
               sel_d   = mem.mem_sel_i;
               addr_d  = mem.mem_addr_i;
               wdata_d = mem.mem_data_i;
               cnt_d   = WAIT_INIT;
               if (WAIT_INIT == '0) begin
                  state_d = ST_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
               go_resp = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (go_resp) begin
         ready_d = 1'b1;
         err_d   = ~in_range;
         if (acc_we) begin
            ram_we = in_range;
         end else begin
            rdata_d = in_range ? ram_q[acc_idx] : 32'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is never reset; byte lanes follow the select bits
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_sel[b]) ram_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   assign mem.mem_data_o  = rdata_q;
   assign mem.mem_ready_o = ready_q;
   assign mem.mem_err_o   = err_q;
   assign mem.stall_req_o = mem.mem_ce_i & ~ready_q;

`ifdef DRAM_ACCESS_CNT_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   // Saturating per-kind access counters, out-of-range accesses included
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (go_resp) begin
         if (acc_we) begin
            if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
         end else begin
            if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
